// File: rtl/spi_frame_receiver_if.sv
// Pin and stream bundle for spi_frame_receiver: SPI slave pins plus the
// rx valid/ready word stream and status flags.
interface spi_frame_receiver_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  sck_i;
  logic                  cs_n_i;
  logic                  mosi_i;
  logic                  miso_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic                  frame_err_o;
  logic                  overrun_o;

  modport slave (
    input  sck_i, cs_n_i, mosi_i, rx_ready_i,
    output miso_o, rx_data_o, rx_valid_o, frame_err_o, overrun_o
  );

  modport master (
    output sck_i, cs_n_i, mosi_i, rx_ready_i,
    input  miso_o, rx_data_o, rx_valid_o, frame_err_o, overrun_o
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave receiving DATA_WIDTH-bit write frames, oversampled in clk_i.
// Optional echo of the previously delivered word on miso: macro SPI_RX_ECHO_EN.
module spi_frame_receiver #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                   clk_i,
  input logic                   rst,
  spi_frame_receiver_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 2);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, CLOSE} state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                    r_sck_hist, r_cs_hist, r_mosi_hist;
  logic                    r_sck_rise, r_cs_rise, r_cs_fall;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_sr;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    r_rx_valid;
  logic                    r_frame_err;
  logic                    r_overrun;
  logic                    w_sck, w_cs, w_mosi;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

`ifdef SPI_RX_ECHO_EN
  logic                    r_sck_fall;
  logic [DATA_WIDTH-1:0]   r_tx;
  logic                    r_miso;
`endif

  // Synchronizers, history flops and registered edge pulses; cs_n resets low
  // so a reset released mid-frame waits for a real cs_n high before IDLE.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_hist  <= 1'b0;
      r_cs_hist   <= 1'b0;
      r_mosi_hist <= 1'b0;
      r_sck_rise  <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_cs_fall   <= 1'b0;
`ifdef SPI_RX_ECHO_EN
      r_sck_fall  <= 1'b0;
`endif
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
      r_sck_hist  <= w_sck;
      r_cs_hist   <= w_cs;
      r_mosi_hist <= w_mosi;
      r_sck_rise  <= w_sck & ~r_sck_hist;
      r_cs_rise   <= w_cs & ~r_cs_hist;
      r_cs_fall   <= ~w_cs & r_cs_hist;
`ifdef SPI_RX_ECHO_EN
      r_sck_fall  <= ~w_sck & r_sck_hist;
`endif
    end
  end

  // Frame FSM, word delivery and status flags.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state     <= WAIT_IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SPI_RX_ECHO_EN
      r_tx        <= '0;
      r_miso      <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      if (r_rx_valid && bus.rx_ready_i) r_rx_valid <= 1'b0;
      case (r_state)
        WAIT_IDLE: if (w_cs) r_state <= IDLE;
        IDLE: begin
          if (r_cs_fall) begin
            r_cnt   <= '0;
            r_sr    <= '0;
            r_state <= SHIFT;
`ifdef SPI_RX_ECHO_EN
            r_tx    <= {r_rx_data[DATA_WIDTH-2:0], 1'b0};
            r_miso  <= r_rx_data[DATA_WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          if (r_sck_rise) begin
            r_sr <= {r_sr[DATA_WIDTH-2:0], r_mosi_hist};
            if (r_cnt != CNT_W'(DATA_WIDTH + 1)) r_cnt <= r_cnt + CNT_W'(1);
          end
`ifdef SPI_RX_ECHO_EN
          if (r_sck_fall) begin
            r_miso <= r_tx[DATA_WIDTH-1];
            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
          end
`endif
          if (r_cs_rise) begin
            r_state <= CLOSE;
`ifdef SPI_RX_ECHO_EN
            r_miso  <= 1'b0;
`endif
          end
        end
        CLOSE: begin
          if (r_cnt == CNT_W'(DATA_WIDTH)) begin
            if (!r_rx_valid || bus.rx_ready_i) begin
              r_rx_data  <= r_sr;
              r_rx_valid <= 1'b1;
            end else begin
              r_overrun  <= 1'b1;
            end
          end else begin
            r_frame_err <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign bus.rx_data_o   = r_rx_data;
  assign bus.rx_valid_o  = r_rx_valid;
  assign bus.frame_err_o = r_frame_err;
  assign bus.overrun_o   = r_overrun;
`ifdef SPI_RX_ECHO_EN
  assign bus.miso_o      = r_miso;
`else
  assign bus.miso_o      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver: directed SPI frames, expected words
// queued at issue time and checked by a handshake monitor.
module tb_spi_frame_receiver;

  localparam int unsigned DW = 32;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;

  spi_frame_receiver_if #(.DATA_WIDTH(DW)) bus ();

  spi_frame_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_xfer   = 0;
  int            n_err    = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] miso_cap;
  logic [DW-1:0] prev_data;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_err   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cs_low();
    bus.cs_n_i = 1'b0;
    repeat (8) tick();
  endtask

  task automatic cs_high();
    repeat (4) tick();
    bus.cs_n_i = 1'b1;
    repeat (10) tick();
  endtask

  // sck period of 8 clk_i cycles; mosi changes on the falling half.
  task automatic send_bit(input logic b);
    bus.mosi_i = b;
    repeat (4) tick();
    bus.sck_i = 1'b1;
    miso_cap  = {miso_cap[DW-2:0], bus.miso_o};
    repeat (4) tick();
    bus.sck_i = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] data, input int nbits);
    cs_low();
    for (int i = nbits - 1; i >= 0; i--) send_bit(data[i]);
    cs_high();
  endtask

  // Monitor: word transfers, data stability under backpressure, error pulses.
  always @(negedge clk_i) begin
    if (!rst) begin
      if (bus.rx_valid_o && bus.rx_ready_i) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(bus.rx_data_o), 64'hDEAD_0000_0000_0000);
        end else begin
          chk("rx_data", 64'(bus.rx_data_o), 64'(exp_q.pop_front()));
        end
      end
      if (prev_valid && !prev_ready && bus.rx_valid_o)
        chk("data_stable", 64'(bus.rx_data_o), 64'(prev_data));
      if (bus.frame_err_o) begin
        n_err++;
        if (prev_err) chk("err_pulse_width", 64'(2), 64'(1));
      end
    end
    prev_valid = bus.rx_valid_o;
    prev_ready = bus.rx_ready_i;
    prev_data  = bus.rx_data_o;
    prev_err   = bus.frame_err_o;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfer0, err0;
    bus.sck_i = 1'b0; bus.cs_n_i = 1'b1; bus.mosi_i = 1'b0; bus.rx_ready_i = 1'b1;
    miso_cap = '0;
    repeat (3) tick();
    chk("rst_valid",   64'(bus.rx_valid_o),  64'(0));
    chk("rst_data",    64'(bus.rx_data_o),   64'(0));
    chk("rst_err",     64'(bus.frame_err_o), 64'(0));
    chk("rst_overrun", 64'(bus.overrun_o),   64'(0));
    chk("rst_miso",    64'(bus.miso_o),      64'(0));
    rst = 1'b0;
    repeat (10) tick();

    // Good frame
    xfer0 = n_xfer; err0 = n_err;
    exp_q.push_back(32'hA5C3_0F81);
    send_frame(64'hA5C3_0F81, 32);
    chk("good_xfers", 64'(n_xfer - xfer0), 64'(1));
    chk("good_no_err", 64'(n_err - err0), 64'(0));

    // Short then long frame
    xfer0 = n_xfer; err0 = n_err;
    send_frame(64'h7FFF_FFFF, 31);
    chk("short_err", 64'(n_err - err0), 64'(1));
    send_frame(64'h1_5555_5555, 33);
    chk("long_err", 64'(n_err - err0), 64'(2));
    chk("bad_no_xfer", 64'(n_xfer - xfer0), 64'(0));
    chk("bad_no_valid", 64'(bus.rx_valid_o), 64'(0));

    // Back-to-back consume
    xfer0 = n_xfer;
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h1234_5678);
    send_frame(64'h0000_0000, 32);
    send_frame(64'hFFFF_FFFF, 32);
    send_frame(64'h1234_5678, 32);
    chk("b2b_xfers", 64'(n_xfer - xfer0), 64'(3));
    chk("b2b_overrun", 64'(bus.overrun_o), 64'(0));

`ifdef SPI_RX_ECHO_EN
    exp_q.push_back(32'hDEAD_BEEF);
    send_frame(64'hDEAD_BEEF, 32);
    exp_q.push_back(32'h0BAD_F00D);
    send_frame(64'h0BAD_F00D, 32);
    chk("echo_miso", 64'(miso_cap), 64'(32'hDEAD_BEEF));
`endif

    // Overrun with backpressure
    xfer0 = n_xfer;
    bus.rx_ready_i = 1'b0;
    exp_q.push_back(32'h1111_1111);
    send_frame(64'h1111_1111, 32);
    send_frame(64'h2222_2222, 32);
    chk("ovr_valid", 64'(bus.rx_valid_o), 64'(1));
    chk("ovr_data", 64'(bus.rx_data_o), 64'(32'h1111_1111));
    chk("ovr_flag", 64'(bus.overrun_o), 64'(1));
    bus.rx_ready_i = 1'b1;
    tick();
    chk("ovr_drop_valid", 64'(bus.rx_valid_o), 64'(0));
    chk("ovr_xfers", 64'(n_xfer - xfer0), 64'(1));
    chk("ovr_sticky", 64'(bus.overrun_o), 64'(1));

    // Reset mid-frame
    cs_low();
    for (int i = 31; i >= 22; i--) send_bit(1'b1);
    rst = 1'b1;
    repeat (3) tick();
    chk("midrst_overrun", 64'(bus.overrun_o), 64'(0));
    rst = 1'b0;
    xfer0 = n_xfer; err0 = n_err;
    for (int i = 21; i >= 0; i--) send_bit(1'b0);
    cs_high();
    chk("midrst_no_xfer", 64'(n_xfer - xfer0), 64'(0));
    chk("midrst_no_err", 64'(n_err - err0), 64'(0));
    exp_q.push_back(32'hCAFE_F00D);
    send_frame(64'hCAFE_F00D, 32);
    chk("post_rst_xfers", 64'(n_xfer - xfer0), 64'(1));

    repeat (5) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
